serial_mag_comp: RTL and testbench
==================================

# serial_mag_comp

Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned operands. Both operands arrive as one bit each per qualified clock cycle. The block produces a registered, one-hot lt/eq/gt result with a done pulse once all WIDTH bit pairs have been consumed. It sits behind serial links and shift-register front ends, where the parallel comparator cannot be used because the operands are never present as whole words.

## Interface
- WIDTH, 8: operand width in bits, WIDTH >= 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a new comparison; accepted in any state.
- bit_valid  input  1  qualifies a_bit/b_bit in the current cycle.
- a_bit  input  1  current bit of operand a (MSB first).
- b_bit  input  1  current bit of operand b (MSB first).
- busy  output  1  high while a comparison is collecting bits.
- done  output  1  one-cycle pulse when the result becomes valid.
- lt  output  1  a < b (held until next start/rst).
- eq  output  1  a == b (held until next start/rst).
- gt  output  1  a > b (held until next start/rst).

## Operation
- States: IDLE, SHIFT.
- IDLE: bit_valid is ignored. start moves the block to SHIFT, clears the bit counter, sets the internal decision to "undecided/equal", and clears lt/eq/gt.
- SHIFT: each cycle with bit_valid=1 samples (a_bit, b_bit) and increments the counter.
- While undecided, the first pair with a_bit != b_bit fixes the decision: a_bit=1 gives gt, else lt. Later pairs never change a fixed decision.
- On the sample that brings the counter to WIDTH, the block returns to IDLE, asserts done for one cycle, and drives exactly one of lt/eq/gt high. eq results if no differing pair was seen.
- Counter width is $clog2(WIDTH+1). It does not wrap: bit_valid is not sampled once WIDTH bits have been taken, because the state is IDLE.
- start in SHIFT is an abort-and-restart: the counter and decision clear, and prior bits are discarded.
- start and bit_valid in the same cycle: start wins, and that cycle's bits are NOT sampled.
- bit_valid=0 cycles in SHIFT are stalls, with no state change.
- Reset in any state, including mid-operation: IDLE, counter 0, busy=0, done=0, lt=eq=gt=0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- busy rises on the edge that samples start and falls on the edge that samples the WIDTH-th valid bit.
- done and lt/eq/gt update on that same edge. Latency from the last valid bit to done is 1 cycle. Minimum start-to-done is WIDTH+1 cycles.
- lt/eq/gt are 0 from the start edge until done. They then hold their value until the next start or rst.
- A new start may be issued in the cycle done is high. done then still pulses for the finished result, and lt/eq/gt clear on the following edge.

## Structure
- Shared package contains:
  - the state enum (IDLE, SHIFT);
  - a 2-bit decision encoding: DEC_EQ=2'b00, DEC_LT=2'b01, DEC_GT=2'b10;
  - a function mapping a decision to one-hot {lt,eq,gt}.
- One sub-module, serial_comp_cell, is natural: a combinational next-decision function of (current decision, a_bit, b_bit). The top level holds the FSM, counter and output registers.

## Test plan
Run with WIDTH=4.
- Reset: assert rst asynchronously mid-cycle -> busy=0, done=0, lt=eq=gt=0 immediately; they stay 0 after release with no start.
- Equal: start, then a=1011, b=1011 on 4 consecutive cycles -> done pulses 1 cycle after the 4th bit, eq=1, lt=gt=0, busy falls on the same edge.
- Early decision: a=1000, b=0111 -> gt=1 only at done, which still occurs after the 4th bit, not the 1st; lt/eq remain 0.
- Stalls: a=0010, b=0011 with bit_valid low for 2 cycles between bits 2 and 3 -> lt=1, done exactly 1 cycle after the 4th valid bit.
- Restart: 2 bits of a=11.., b=00.., then start, then a=0001, b=0000 -> gt=1 from the new bits only. Also check that start coincident with bit_valid does not count that bit.
- Reset mid-operation: rst after 3 bits -> all outputs 0. A following full comparison a=0101, b=0110 -> lt=1.

Source files
------------

// File: rtl/serial_mag_comp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_mag_comp_pkg;

   // Control states: waiting for a start, or collecting bit pairs.
   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StShift = 1'b1
   } state_e;

   // Running decision. Equal also means "undecided so far".
   typedef enum logic [1:0] {
      DecEq = 2'b00,
      DecLt = 2'b01,
      DecGt = 2'b10
   } decision_e;

   // Map a decision to the one-hot {lt, eq, gt} result.
   function automatic logic [2:0] dec_to_onehot(decision_e dec);
      logic [2:0] res;
      res = 3'b000;
      case (dec)
         DecLt:   res = 3'b100;
         DecEq:   res = 3'b010;
         DecGt:   res = 3'b001;
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Bit-serial operand stream plus registered comparison result.
interface serial_mag_comp_if;

   logic start;
   logic bit_valid;
   logic a_bit;
   logic b_bit;
   logic busy;
   logic done;
   logic lt;
   logic eq;
   logic gt;

   // Producer of operand bits and consumer of the result.
   modport master (
      output start, bit_valid, a_bit, b_bit,
      input  busy, done, lt, eq, gt
   );

   // The comparator itself.
   modport slave (
      input  start, bit_valid, a_bit, b_bit,
      output busy, done, lt, eq, gt
   );

endinterface

// File: rtl/serial_comp_cell.sv
// Next-decision function for one MSB-first bit pair.
module serial_comp_cell
   import serial_mag_comp_pkg::*;
(
   input  decision_e dec_i,
   input  logic      a_bit_i,
   input  logic      b_bit_i,
   output decision_e dec_o
);

   // The first differing pair fixes the decision; later pairs are ignored.
   always_comb begin
      dec_o = dec_i;
      if (dec_i == DecEq && a_bit_i != b_bit_i) begin
         dec_o = a_bit_i ? DecGt : DecLt;
      end
   end

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial MSB-first unsigned magnitude comparator with registered one-hot result.
module serial_mag_comp
   import serial_mag_comp_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   serial_mag_comp_if.slave   bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   decision_e       dec_q, dec_d;
   decision_e       dec_nxt;
   logic [2:0]      res_q, res_d;
   logic            done_q, done_d;

   serial_comp_cell u_cell (
      .dec_i   (dec_q),
      .a_bit_i (bus.a_bit),
      .b_bit_i (bus.b_bit),
      .dec_o   (dec_nxt)
   );

   // Next-state: start always wins (abort-and-restart); otherwise sample valid bits in SHIFT.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      res_d   = res_q;
      done_d  = 1'b0;
      if (bus.start) begin
         state_d = StShift;
         cnt_d   = '0;
         dec_d   = DecEq;
         res_d   = 3'b000;
      end else if (state_q == StShift && bus.bit_valid) begin
         cnt_d = cnt_q + CntW'(1);
         dec_d = dec_nxt;
         if (cnt_q == LastCnt) begin
            state_d = StIdle;
            done_d  = 1'b1;
            res_d   = dec_to_onehot(dec_nxt);
         end
      end
   end

   // State, counter, decision and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dec_q   <= DecEq;
         res_q   <= 3'b000;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q == StShift);
   assign bus.done = done_q;
   assign bus.lt   = res_q[2];
   assign bus.eq   = res_q[1];
   assign bus.gt   = res_q[0];

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed, table-driven bench for serial_mag_comp with WIDTH=4.
module tb_serial_mag_comp;

   localparam int unsigned W = 4;
   localparam logic [2:0] RLt = 3'b100;
   localparam logic [2:0] REq = 3'b010;
   localparam logic [2:0] RGt = 3'b001;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   serial_mag_comp_if bus_if ();

   serial_mag_comp #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] a;
      logic [3:0] b;
      int         stall_pos;  // valid-bit index before which stalls are inserted
      int         stall_len;
      bit         coinc;      // bit_valid high (with a=1,b=0) in the start cycle
      logic [2:0] exp;        // {lt, eq, gt}
   } vec_t;

   vec_t vecs[8];

   function automatic logic [2:0] res();
      return {bus_if.lt, bus_if.eq, bus_if.gt};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input string name, input bit coinc);
      bus_if.start     = 1'b1;
      bus_if.bit_valid = coinc;
      bus_if.a_bit     = 1'b1;
      bus_if.b_bit     = 1'b0;
      step();
      bus_if.start     = 1'b0;
      bus_if.bit_valid = 1'b0;
      chk({name, " busy after start"}, 32'(bus_if.busy), 32'd1);
      chk({name, " result cleared by start"}, 32'(res()), 32'd0);
   endtask

   // Feed WIDTH bits MSB first; leaves the bench in the done cycle.
   task automatic feed(input string name, input logic [3:0] a, input logic [3:0] b,
                       input int stall_pos, input int stall_len, input logic [2:0] exp);
      for (int k = 0; k < 4; k++) begin
         if (k == stall_pos) begin
            for (int s = 0; s < stall_len; s++) begin
               bus_if.bit_valid = 1'b0;
               bus_if.a_bit     = ~a[3-k];
               bus_if.b_bit     = ~b[3-k];
               step();
               chk({name, " stall busy"}, 32'(bus_if.busy), 32'd1);
               chk({name, " stall done"}, 32'(bus_if.done), 32'd0);
            end
         end
         bus_if.bit_valid = 1'b1;
         bus_if.a_bit     = a[3-k];
         bus_if.b_bit     = b[3-k];
         step();
         if (k < 3) begin
            chk({name, " early done"}, 32'(bus_if.done), 32'd0);
            chk({name, " early result"}, 32'(res()), 32'd0);
         end else begin
            chk({name, " done"}, 32'(bus_if.done), 32'd1);
            chk({name, " busy falls"}, 32'(bus_if.busy), 32'd0);
            chk({name, " result"}, 32'(res()), 32'(exp));
         end
      end
      bus_if.bit_valid = 1'b0;
   endtask

   task automatic run_cmp(input vec_t v);
      do_start(v.name, v.coinc);
      feed(v.name, v.a, v.b, v.stall_pos, v.stall_len, v.exp);
      step();
      chk({v.name, " done one cycle"}, 32'(bus_if.done), 32'd0);
      chk({v.name, " result held"}, 32'(res()), 32'(v.exp));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      vecs[0] = '{"equal",    4'b1011, 4'b1011, -1, 0, 1'b0, REq};
      vecs[1] = '{"early_gt", 4'b1000, 4'b0111, -1, 0, 1'b0, RGt};
      vecs[2] = '{"stall_lt", 4'b0010, 4'b0011,  2, 2, 1'b0, RLt};
      vecs[3] = '{"zeros",    4'b0000, 4'b0000, -1, 0, 1'b0, REq};
      vecs[4] = '{"lsb_gt",   4'b1111, 4'b1110,  1, 1, 1'b0, RGt};
      vecs[5] = '{"mid_lt",   4'b0101, 4'b0110, -1, 0, 1'b0, RLt};
      vecs[6] = '{"coinc_lt", 4'b0000, 4'b0001, -1, 0, 1'b1, RLt};
      vecs[7] = '{"ones_eq",  4'b1111, 4'b1111,  0, 3, 1'b1, REq};

      bus_if.start     = 1'b0;
      bus_if.bit_valid = 1'b0;
      bus_if.a_bit     = 1'b0;
      bus_if.b_bit     = 1'b0;
      rst = 1'b1;
      #12;
      rst = 1'b0;

      // Idle after reset: bits without start are ignored.
      bus_if.bit_valid = 1'b1;
      bus_if.a_bit     = 1'b1;
      for (int i = 0; i < 6; i++) step();
      bus_if.bit_valid = 1'b0;
      chk("reset busy", 32'(bus_if.busy), 32'd0);
      chk("reset done", 32'(bus_if.done), 32'd0);
      chk("reset result", 32'(res()), 32'd0);

      foreach (vecs[i]) run_cmp(vecs[i]);

      // Asynchronous reset mid-cycle clears a held result immediately.
      #3;
      rst = 1'b1;
      #1;
      chk("async rst result", 32'(res()), 32'd0);
      chk("async rst busy", 32'(bus_if.busy), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("post rst result", 32'(res()), 32'd0);

      // Restart after 2 bits that favour lt: decision and counter must clear.
      do_start("restart", 1'b0);
      bus_if.bit_valid = 1'b1;
      bus_if.a_bit     = 1'b0;
      bus_if.b_bit     = 1'b1;
      step();
      step();
      run_cmp('{"restart_gt", 4'b0001, 4'b0000, -1, 0, 1'b0, RGt});

      // Start issued in the done cycle: done still pulsed, result clears next edge.
      do_start("b2b", 1'b0);
      feed("b2b_first", 4'b0001, 4'b0000, -1, 0, RGt);
      do_start("b2b_second", 1'b0);
      chk("b2b done dropped", 32'(bus_if.done), 32'd0);
      feed("b2b_second", 4'b0100, 4'b0100, -1, 0, REq);
      step();

      // Reset after 3 bits, then a full comparison.
      do_start("midrst", 1'b0);
      bus_if.bit_valid = 1'b1;
      bus_if.a_bit     = 1'b1;
      bus_if.b_bit     = 1'b0;
      for (int i = 0; i < 3; i++) step();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst busy", 32'(bus_if.busy), 32'd0);
      chk("midrst done", 32'(bus_if.done), 32'd0);
      chk("midrst result", 32'(res()), 32'd0);
      bus_if.bit_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("midrst stays idle", 32'(bus_if.busy), 32'd0);
      run_cmp('{"after_rst_lt", 4'b0101, 4'b0110, -1, 0, 1'b0, RLt});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
